dac_output_stage: RTL and testbench

//  Post-EQ output stage between three_band_eq.audio_out and the I2S TX sample_dat_i.

---
 rtl/dac_output_stage.sv | 153 +++++++++++++++
 tb/tb_dac_output_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dac_output_stage.sv
// Post-EQ DAC output stage: Q2.6 gain, soft-mute ramp, 16-bit saturation, tear-free DAC word.
// Optional feature macro DAC_STAGE_CLIP_COUNT_EN adds a saturating clip_count output.
module dac_output_stage #(
    parameter int AUDIO_W   = 16,
    parameter int GAIN_FRAC = 6,
    parameter int RAMP_STEP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      l_r_clk,
    input  logic signed [AUDIO_W-1:0] audio_in,
    input  logic [7:0]                gain,
    input  logic                      mute_req,
    input  logic                      dac_request,
    output logic [31:0]               dac_data,
    output logic                      muted,
`ifdef DAC_STAGE_CLIP_COUNT_EN
    output logic [15:0]               clip_count,
`endif
    output logic                      clip
);

    localparam int P1_W   = AUDIO_W + 9;
    localparam int PROD_W = P1_W + 10;
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-AUDIO_W+1){1'b0}}, {(AUDIO_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-AUDIO_W+1){1'b1}}, {(AUDIO_W-1){1'b0}}};

    typedef enum logic [1:0] {MUTED, RAMP_UP, UNMUTED, RAMP_DOWN} mute_state_e;

    logic [2:0]                sync_q;
    logic                      tick_q;
    mute_state_e               state_q, state_d;
    logic [8:0]                level_q, level_d;
    logic                      v1_q, v2_q;
    logic signed [P1_W-1:0]    p1_q;
    logic [8:0]                lvl_s1_q;
    logic signed [PROD_W-1:0]  p2_q;
    logic [AUDIO_W-1:0]        out_s_q;
    logic                      pending_q;
    logic                      clip_q;
    logic [31:0]               dac_q;

    logic signed [P1_W-1:0]    audio_x, gain_x, p1_d;
    logic signed [PROD_W-1:0]  p1_x, lvl_x, p2_d, p3;
    logic                      sat_hi, sat_lo;
    logic [AUDIO_W-1:0]        out_d;
    logic [9:0]                lvl_up_w;
    logic [8:0]                lvl_up, lvl_dn;

    // Datapath: all operands are widened first so every product is exact.
    always_comb begin
        audio_x = P1_W'(audio_in);
        gain_x  = $signed({{(P1_W-8){1'b0}}, gain});
        p1_d    = audio_x * gain_x;
        p1_x    = PROD_W'(p1_q);
        lvl_x   = $signed({{(PROD_W-9){1'b0}}, lvl_s1_q});
        p2_d    = (p1_x * lvl_x) >>> 8;
        p3      = p2_q >>> GAIN_FRAC;
        sat_hi  = (p3 > SAT_MAX);
        sat_lo  = (p3 < SAT_MIN);
        if (sat_hi)      out_d = SAT_MAX[AUDIO_W-1:0];
        else if (sat_lo) out_d = SAT_MIN[AUDIO_W-1:0];
        else             out_d = p3[AUDIO_W-1:0];
    end

    // Mute FSM; moves only on a word-select tick, clamping at both ends of 0..256.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_d  = state_q;
        level_d  = level_q;
        lvl_up_w = {1'b0, level_q} + 10'(RAMP_STEP);
        lvl_up   = (lvl_up_w >= 10'd256) ? 9'd256 : lvl_up_w[8:0];
        lvl_dn   = (level_q <= 9'(RAMP_STEP)) ? 9'd0 : level_q - 9'(RAMP_STEP);
        if (tick_q) begin
            unique case (state_q)
                MUTED, RAMP_DOWN, RAMP_UP, UNMUTED: begin
                    if (mute_req) begin
                        level_d = lvl_dn;
                        state_d = (lvl_dn == 9'd0) ? MUTED : RAMP_DOWN;
                    end else begin
                        level_d = lvl_up;
                        state_d = (lvl_up == 9'd256) ? UNMUTED : RAMP_UP;
                    end
                end
                default: begin
                    state_d = MUTED;
                    level_d = 9'd0;
                end
            endcase
        end
    end

    // NOTE: synchronous reset covers pipeline data too, so a pending sample is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            tick_q  <= 1'b0;
            state_q <= MUTED;
            level_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the sync chain a true shift register.
            sync_q  <= {sync_q[1:0], l_r_clk};
            tick_q  <= sync_q[1] & ~sync_q[2];
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            p1_q      <= '0;
            lvl_s1_q  <= '0;
            p2_q      <= '0;
            out_s_q   <= '0;
            pending_q <= 1'b0;
            clip_q    <= 1'b0;
            dac_q     <= '0;
        end else begin
            v1_q <= tick_q;
            v2_q <= v1_q;
            if (tick_q) begin
                p1_q     <= p1_d;
                lvl_s1_q <= level_q;
            end
            if (v1_q) p2_q <= p2_d;
            clip_q <= v2_q & (sat_hi | sat_lo);
            // The codec reads dac_data while dac_request is high; only update outside it.
            if (pending_q && !dac_request) dac_q <= {8'h00, out_s_q, 8'h00};
            if (v2_q) begin
                out_s_q   <= out_d;
                pending_q <= 1'b1;
            end else if (pending_q && !dac_request) begin
                pending_q <= 1'b0;
            end
        end
    end

`ifdef DAC_STAGE_CLIP_COUNT_EN
    logic [15:0] clip_count_q;
    always_ff @(posedge clk) begin
        if (reset)                                   clip_count_q <= '0;
        else if (clip_q && clip_count_q != 16'hFFFF) clip_count_q <= clip_count_q + 16'd1;
    end
    assign clip_count = clip_count_q;
`endif

    assign dac_data = dac_q;
    assign muted    = (state_q == MUTED);
    assign clip     = clip_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed self-checking bench for dac_output_stage; levels are observed through dac_data
// (gain 64, audio 0x1000 gives sample = 16 * level used).
module tb_dac_output_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        l_r_clk;
    logic [15:0] audio_in;
    logic [7:0]  gain;
    logic        mute_req;
    logic        dac_request;
    logic [31:0] dac_data;
    logic        muted;
    logic        clip;
`ifdef DAC_STAGE_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    int total = 0;
    int bad   = 0;
    int clip_seen;
    int exp_level;

    always #5 clk = ~clk;

    dac_output_stage dut (
        .clk         (clk),
        .reset       (reset),
        .l_r_clk     (l_r_clk),
        .audio_in    (audio_in),
        .gain        (gain),
        .mute_req    (mute_req),
        .dac_request (dac_request),
        .dac_data    (dac_data),
        .muted       (muted),
`ifdef DAC_STAGE_CLIP_COUNT_EN
        .clip_count  (clip_count),
`endif
        .clip        (clip)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [15:0] s);
        return {8'h00, s, 8'h00};
    endfunction

    function automatic int next_level(input int l, input logic m);
        if (m) return (l - 4 < 0) ? 0 : l - 4;
        return (l + 4 > 256) ? 256 : l + 4;
    endfunction

    // One word-select pulse, long enough for the sample to reach dac_data when not blocked.
    task automatic lr_tick();
        clip_seen = 0;
        l_r_clk = 1'b1;
        repeat (4) begin @(negedge clk); if (clip === 1'b1) clip_seen++; end
        l_r_clk = 1'b0;
        repeat (6) begin @(negedge clk); if (clip === 1'b1) clip_seen++; end
    endtask

    // Ticks with gain 64 / audio 0x1000, checking each output against the level model.
    task automatic run_ramp(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            lr_tick();
            check(tag, dac_data, word(16'(exp_level * 16)));
            exp_level = next_level(exp_level, mute_req);
        end
    endtask

    initial begin
        reset = 1'b1; l_r_clk = 1'b0; audio_in = 16'h1000; gain = 8'd64;
        mute_req = 1'b0; dac_request = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dac", dac_data, 32'h0);
        check("rst_muted", {31'h0, muted}, 32'h1);
        check("rst_clip", {31'h0, clip}, 32'h0);
`ifdef DAC_STAGE_CLIP_COUNT_EN
        check("rst_clip_count", {16'h0, clip_count}, 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Ramp up half way, reverse for 8 ticks, then finish ramping up.
        exp_level = 0;
        lr_tick();
        check("first_tick_dac", dac_data, 32'h0);
        check("first_tick_muted", {31'h0, muted}, 32'h0);
        exp_level = 4;
        run_ramp(31, "ramp_up_a");
        check("level_128", 32'(exp_level), 32'd128);
        mute_req = 1'b1;
        run_ramp(8, "ramp_down_mid");
        mute_req = 1'b0;
        run_ramp(40, "ramp_up_b");
        lr_tick();
        check("unity_full", dac_data, 32'h00100000);
        check("unmuted", {31'h0, muted}, 32'h0);

        // Saturation in both directions.
        gain = 8'd255; audio_in = 16'h4000;
        lr_tick();
        check("sat_pos", dac_data, 32'h007FFF00);
        check("clip_pos", 32'(clip_seen), 32'd1);
        audio_in = 16'hC000;
        lr_tick();
        check("sat_neg", dac_data, 32'h00800000);
        check("clip_neg", 32'(clip_seen), 32'd1);
`ifdef DAC_STAGE_CLIP_COUNT_EN
        check("clip_count_2", {16'h0, clip_count}, 32'd2);
`endif

        // Floor rounding and zero gain.
        gain = 8'd32; audio_in = 16'hFFFE;
        lr_tick();
        check("floor_neg", dac_data, 32'h00FFFF00);
        check("floor_noclip", 32'(clip_seen), 32'd0);
        gain = 8'd0;
        lr_tick();
        check("gain_zero", dac_data, 32'h0);
        check("gain_zero_muted", {31'h0, muted}, 32'h0);

        // dac_request blocks the update until it drops.
        gain = 8'd64; audio_in = 16'h0100; dac_request = 1'b1;
        lr_tick();
        check("req_hold", dac_data, 32'h0);
        dac_request = 1'b0;
        @(negedge clk);
        check("req_release", dac_data, 32'h00010000);

        // Full fade to silence.
        audio_in = 16'h1000; mute_req = 1'b1; exp_level = 256;
        run_ramp(64, "ramp_down_full");
        check("muted_after_fade", {31'h0, muted}, 32'h1);
        lr_tick();
        check("silent", dac_data, 32'h0);

        // Reset mid-ramp with a sample held pending by dac_request.
        mute_req = 1'b0; exp_level = 0;
        run_ramp(3, "pre_reset");
        check("pre_reset_val", dac_data, 32'h00008000);
        dac_request = 1'b1;
        lr_tick();
        check("pending_held", dac_data, 32'h00008000);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_dac", dac_data, 32'h0);
        check("mid_rst_muted", {31'h0, muted}, 32'h1);
        check("mid_rst_clip", {31'h0, clip}, 32'h0);
`ifdef DAC_STAGE_CLIP_COUNT_EN
        check("mid_rst_clip_count", {16'h0, clip_count}, 32'h0);
`endif
        reset = 1'b0; dac_request = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_dropped", dac_data, 32'h0);
        lr_tick();
        check("post_rst_lvl0", dac_data, 32'h0);
        check("post_rst_muted", {31'h0, muted}, 32'h0);
        lr_tick();
        check("post_rst_lvl4", dac_data, 32'h00004000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
